// File: rtl/alu_cmd_driver_if.sv
// Opcode definitions and the command/ALU/response bundle shared by
// alu_cmd_driver and whatever drives or consumes it.
package alu_cmd_driver_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_XOR = 2'd3
  } opcode_e;
endpackage

interface alu_cmd_driver_if #(
  parameter int TAG_W = 4
);
  import alu_cmd_driver_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  opcode_e          cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  opcode_e          alu_op;
  logic [15:0]      alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  logic [15:0]      issue_count;

  // The command source and response sink side of the block.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result,
    input  rsp_valid, rsp_result, rsp_tag, issue_count,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result,
    output rsp_valid, rsp_result, rsp_tag, issue_count,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands in a small FIFO, drives the head entry to an external
// combinational ALU and holds each result in a one-deep response register.
module alu_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  alu_cmd_driver_if.slave bus
);
  import alu_cmd_driver_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    opcode_e          op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  state_e           state;
  logic [15:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [15:0]      issue_count_q;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             issue;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push       = bus.cmd_valid && !fifo_full;
  assign issue      = !fifo_empty && ((state == S_EMPTY) || bus.rsp_ready);
  assign head       = mem[rd_ptr[PW-1:0]];

  assign bus.cmd_ready   = !fifo_full;
  assign bus.alu_a       = fifo_empty ? 8'd0 : head.a;
  assign bus.alu_b       = fifo_empty ? 8'd0 : head.b;
  assign bus.alu_op      = fifo_empty ? OP_ADD : head.op;
  assign bus.rsp_valid   = (state == S_FULL);
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign bus.issue_count = issue_count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= '{a: bus.cmd_a, b: bus.cmd_b,
                               op: bus.cmd_op, tag: bus.cmd_tag};
    end
  end

  // An issue refills the response register even while the previous
  // response is being taken, which gives one response per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      state         <= S_EMPTY;
      rsp_result_q  <= '0;
      rsp_tag_q     <= '0;
      issue_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (issue) begin
        rd_ptr        <= rd_ptr + PTR_ONE;
        rsp_result_q  <= bus.alu_result;
        rsp_tag_q     <= head.tag;
        issue_count_q <= issue_count_q + 16'd1;
        state         <= S_FULL;
      end else if ((state == S_FULL) && bus.rsp_ready) begin
        state <= S_EMPTY;
      end
    end
  end
endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 4: command FIFO entries (power of 2, at least 2).
REQ-002 The block SHALL have parameter TAG_W, default 4: command tag width.
Ports:
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 The block SHALL have port cmd_valid, input, 1: upstream command present.
REQ-006 The block SHALL have port cmd_ready, output, 1: block accepts a command this cycle.
REQ-007 The block SHALL have ports cmd_a and cmd_b, input, 8 each: operands.
REQ-008 The block SHALL have port cmd_op, input, opcode_e (2 bits): ADD=0, SUB=1, MUL=2, XOR=3.
REQ-009 The block SHALL have port cmd_tag, input, TAG_W: command identifier, returned with the result.
REQ-010 The block SHALL have ports alu_a and alu_b, output, 8 each; and alu_op, output, opcode_e: operands and opcode driven to the external combinational ALU.
REQ-011 The block SHALL have port alu_result, input, 16: combinational ALU result for the currently driven alu_a, alu_b and alu_op.
REQ-012 The block SHALL have ports rsp_valid, output, 1; and rsp_ready, input, 1: response handshake.
REQ-013 The block SHALL have ports rsp_result, output, 16; and rsp_tag, output, TAG_W: captured result and its tag.
REQ-014 The block SHALL have port issue_count, output, 16: number of commands issued to the ALU.

Function
REQ-015 A command SHALL be accepted on a clock edge where cmd_valid=1 and cmd_ready=1, and written to the tail of the FIFO; cmd_ready SHALL equal !fifo_full, with no bypass when full.
REQ-016 When the FIFO is non-empty, alu_a, alu_b and alu_op SHALL be driven combinationally from the head entry; when it is empty they SHALL be driven to 0, 0 and ADD.
REQ-017 Response register FSM: states EMPTY and FULL; rsp_valid=1 if and only if the state is FULL.
REQ-018 An issue SHALL occur on an edge where the FIFO is non-empty and (state is EMPTY or rsp_ready=1); an issue captures alu_result into rsp_result and the head tag into rsp_tag, pops the head, and sets the state to FULL.
REQ-019 On an edge with rsp_valid=1, rsp_ready=1 and no issue, the state SHALL go FULL to EMPTY.
REQ-020 While rsp_valid=1 and rsp_ready=0, rsp_result and rsp_tag SHALL remain stable.
REQ-021 Minimum latency SHALL be 2 cycles: a command accepted at edge N, into an empty FIFO with EMPTY state, is issued at edge N+1, with rsp_valid high after edge N+1.
REQ-022 Throughput SHALL be 1 response per cycle when rsp_ready is held at 1 and the FIFO is non-empty.
REQ-023 A push and a pop on the same edge SHALL leave the FIFO occupancy unchanged; this is legal whenever the FIFO is not full.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit or by an occupancy counter.
REQ-025 Commands SHALL be processed strictly in order; responses SHALL return in acceptance order.
REQ-026 issue_count SHALL increment by 1 on every issue and wrap from 0xFFFF to 0x0000.
REQ-027 Result width rules SHALL follow the ALU: SUB yields a 16-bit two's-complement wrap, MUL yields the full 16-bit product, and ADD and XOR are zero-extended.
REQ-028 The maximum number of outstanding commands SHALL be DEPTH+1 (FIFO entries plus response register).

Reset
REQ-029 When rst_n=0 at a clock edge, the FIFO SHALL be emptied, the state set to EMPTY, and issue_count cleared to 0.
REQ-030 After reset, the outputs SHALL be: cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_tag=0, alu_a=0, alu_b=0, alu_op=ADD, issue_count=0.
REQ-031 A reset asserted mid-operation SHALL discard all queued and pending commands with no response emitted; a command presented during the reset cycle SHALL NOT be accepted.

Verification
REQ-032 The bench SHALL cover single ADD: a=200, b=100, tag=3, rsp_ready=1 -> rsp_valid 2 cycles later, rsp_result=0x012C, rsp_tag=3, issue_count=1.
REQ-033 The bench SHALL cover back-to-back SUB 5-10, MUL 255*255, XOR 0xA5^0x0F with rsp_ready=1 -> consecutive responses 0xFFFB, 0xFE01, 0x00AA in order.
REQ-034 The bench SHALL cover backpressure with DEPTH=4 and rsp_ready=0, pushing 6 commands -> 5 accepted, cmd_ready=0 on the 6th, and rsp_result stable.
REQ-035 The bench SHALL cover draining that backpressured state with rsp_ready=1 -> 5 responses on 5 consecutive cycles with tags in order, then rsp_valid=0.
REQ-036 The bench SHALL cover a simultaneous push and pop with the FIFO at 2 entries -> occupancy stays at 2 and no entry is lost or duplicated.
REQ-037 The bench SHALL cover rst_n=0 for one cycle with 3 commands queued and rsp_valid=1 -> the next cycle shows rsp_valid=0, cmd_ready=1, issue_count=0, and no stale responses later.
